// File: rtl/router_pkg.sv
// router_pkg: shared router constants and output-arbiter state type
package router_pkg;
   localparam int N_PORTS = 16;
   localparam int ADDR_W  = 4;
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
endpackage

// File: rtl/out_port_arbiter_if.sv
// out_port_arbiter_if: request/grant bundle between the input channels and one output arbiter
interface out_port_arbiter_if import router_pkg::*; #(
   parameter int N_IN = N_PORTS
);
   localparam int IW = $clog2(N_IN);
   logic [N_IN-1:0] req;
   logic [N_IN-1:0] frame_n;
   logic [N_IN-1:0] grant;
   logic [IW-1:0]   grant_idx;
   logic            grant_valid;
   logic            busy;
   logic            abort;
   modport master (input req, frame_n, output grant, grant_idx, grant_valid, busy, abort);
   modport slave  (output req, frame_n, input grant, grant_idx, grant_valid, busy, abort);
endinterface

// File: rtl/out_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first request at or after ptr
module rr_pick #(
   parameter int N_IN = 16,
   localparam int IW = $clog2(N_IN)
) (
   input  logic [N_IN-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [N_IN-1:0] win_o,
   output logic [IW-1:0]   win_idx_o,
   output logic            any_o
);
   logic [N_IN-1:0] rot;
   logic [IW-1:0]   off;
   logic [IW:0]     sum;
   // rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back
   always_comb begin
      rot = (req_i >> ptr_i) | (req_i << (N_IN - int'(ptr_i)));
      off = '0;
      for (int i = N_IN - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
      sum = {1'b0, off} + {1'b0, ptr_i};
      win_idx_o = (sum >= (IW+1)'(N_IN)) ? IW'(sum - (IW+1)'(N_IN)) : sum[IW-1:0];
      any_o = |req_i;
      win_o = any_o ? N_IN'(1) << win_idx_o : '0;
   end
endmodule

// File: rtl/out_port_arbiter.sv
// out_port_arbiter: round-robin owner of one router output port with frame hold and watchdog
module out_port_arbiter import router_pkg::*; #(
   parameter int N_IN     = N_PORTS,
   parameter int MAX_HOLD = 1024
) (
   input logic                clk,
   input logic                reset,
   out_port_arbiter_if.master bus
);
   localparam int IW = $clog2(N_IN);
   localparam int HW = $clog2(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   arb_state_t      state_q;
   logic [N_IN-1:0] grant_q, win;
   logic [IW-1:0]   idx_q, ptr_q, ptr_d, win_idx;
   logic [HW-1:0]   hold_q;
   logic            valid_q, busy_q, abort_q, any, owner_done;
   rr_pick #(.N_IN(N_IN)) u_pick (
      .req_i     (bus.req),
      .ptr_i     (ptr_q),
      .win_o     (win),
      .win_idx_o (win_idx),
      .any_o     (any)
   );
   // pointer just past the winner, and the owner ending or abandoning its frame
   always_comb begin
      ptr_d = (win_idx == IW'(N_IN - 1)) ? '0 : win_idx + 1'b1;
      owner_done = bus.frame_n[idx_q] | ~bus.req[idx_q];
   end
   // arbitration FSM; owner release takes priority over the watchdog
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         abort_q <= 1'b0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         abort_q <= 1'b0;
         case (state_q)
            IDLE: if (any) begin
               state_q <= GRANT;
               grant_q <= win;
               idx_q   <= win_idx;
               valid_q <= 1'b1;
               busy_q  <= 1'b1;
               ptr_q   <= ptr_d;
               hold_q  <= '0;
            end
            GRANT: if (owner_done || hold_q == HOLD_LAST) begin
               state_q <= RELEASE;
               grant_q <= '0;
               valid_q <= 1'b0;
               abort_q <= ~owner_done;
            end else begin
               hold_q <= hold_q + 1'b1;
            end
            RELEASE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.grant       = grant_q;
   assign bus.grant_idx   = idx_q;
   assign bus.grant_valid = valid_q;
   assign bus.busy        = busy_q;
   assign bus.abort       = abort_q;
endmodule

// File: tb/tb_out_port_arbiter.sv
// tb_out_port_arbiter: directed and randomized scoreboard bench for out_port_arbiter
module tb_out_port_arbiter;
   localparam int N = router_pkg::N_PORTS;
   localparam int MAX_HOLD = 8;
   localparam int K_GRANT = 0, K_REL = 1, K_ABORT = 2, K_IDLE = 3, K_STRAY = 4;
   typedef struct {int kind; int idx; int cyc;} ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   out_port_arbiter_if #(.N_IN(N)) bus ();
   out_port_arbiter #(.N_IN(N), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .reset(reset), .bus(bus));

   ev_t  exp_q[$];
   int   cyc = 0, n_chk = 0, n_fail = 0;
   int   owner = -1, ptr = 0, held = 0, cur_idx = 0;
   bit   in_rel = 1'b0;
   logic pv = 1'b0, pb = 1'b0;

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach its end, expected completion");
      $fatal(1, "timeout");
   end

   function automatic void push(input int k, input int i);
      exp_q.push_back('{k, i, cyc});
   endfunction

   // reference model: owner, rotating pointer and visible-grant length, stepped per sampled edge
   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         if (owner >= 0) push(K_REL, 0);
         if (owner >= 0 || in_rel) push(K_IDLE, 0);
         owner = -1;
         ptr = 0;
         in_rel = 1'b0;
      end else if (owner >= 0) begin
         if (bus.frame_n[owner] || !bus.req[owner]) begin
            push(K_REL, 0);
            owner = -1;
            in_rel = 1'b1;
         end else if (held == MAX_HOLD) begin
            push(K_ABORT, 0);
            owner = -1;
            in_rel = 1'b1;
         end else begin
            held++;
         end
      end else if (in_rel) begin
         push(K_IDLE, 0);
         in_rel = 1'b0;
      end else if (bus.req != '0) begin
         for (int j = 0; j < N; j++) begin
            if (bus.req[(ptr + j) % N]) begin
               owner = (ptr + j) % N;
               break;
            end
         end
         push(K_GRANT, owner);
         ptr = (owner + 1) % N;
         held = 1;
      end
   end

   task automatic observe(input int k, input int i);
      ev_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL event: got kind=%0d idx=%0d cycle=%0d, expected no event", k, i, cyc);
         return;
      end
      e = exp_q.pop_front();
      if (k == K_GRANT) cur_idx = e.idx;
      if (e.kind != k || e.idx != i || e.cyc != cyc ||
          (k == K_GRANT && (bus.grant != (N'(1) << e.idx) || !bus.busy))) begin
         n_fail++;
         $display("FAIL event: got kind=%0d idx=%0d cycle=%0d grant=%h busy=%b, expected kind=%0d idx=%0d cycle=%0d",
                  k, i, cyc, bus.grant, bus.busy, e.kind, e.idx, e.cyc);
      end
   endtask

   // monitor: turn output transitions into events and check the grant vector every cycle
   always @(negedge clk) begin
      if (bus.grant_valid && !pv) observe(K_GRANT, int'(bus.grant_idx));
      else if (!bus.grant_valid && pv) observe(bus.abort ? K_ABORT : K_REL, 0);
      else if (bus.abort || (bus.busy && !pb)) observe(K_STRAY, 0);
      if (!bus.busy && pb) observe(K_IDLE, 0);
      n_chk++;
      if (bus.grant !== (bus.grant_valid ? N'(1) << cur_idx : N'(0))) begin
         n_fail++;
         $display("FAIL grant_vec: got %h, expected %h at cycle %0d",
                  bus.grant, bus.grant_valid ? N'(1) << cur_idx : N'(0), cyc);
      end
      pv = bus.grant_valid;
      pb = bus.busy;
   end

   task automatic step(input logic [N-1:0] r, input logic [N-1:0] f, input int n);
      repeat (n) begin
         @(negedge clk);
         bus.req = r;
         bus.frame_n = f;
      end
   endtask

   task automatic do_reset(input logic [N-1:0] r);
      @(negedge clk);
      reset = 1'b1;
      bus.req = r;
      bus.frame_n = '0;
      @(negedge clk);
      n_chk++;
      if ({bus.grant, bus.grant_idx, bus.grant_valid, bus.busy, bus.abort} !== '0) begin
         n_fail++;
         $display("FAIL reset: got grant=%h idx=%0d valid=%b busy=%b abort=%b, expected all zero",
                  bus.grant, bus.grant_idx, bus.grant_valid, bus.busy, bus.abort);
      end
      reset = 1'b0;
   endtask

   initial begin
      int t;
      logic [N-1:0] r, f;
      bus.req = '0;
      bus.frame_n = '1;
      do_reset('0);
      step(16'h0004, 16'h0000, 3);
      n_chk++;
      if (bus.grant !== 16'h0004 || bus.grant_idx !== 4'd2 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single: got grant=%h idx=%0d busy=%b, expected grant=0004 idx=2 busy=1",
                  bus.grant, bus.grant_idx, bus.busy);
      end
      step(16'h0004, 16'h0004, 1);
      step('0, '1, 3);
      do_reset('0);
      step(16'h8001, 16'h0000, 3);
      step(16'h8001, 16'h0001, 5);
      step(16'h8001, 16'h8001, 1);
      step('0, '1, 3);
      do_reset(16'hFFFF);
      for (int g = 0; g < 17; g++) begin
         t = 0;
         while (!bus.grant_valid && t < 20) begin
            step(16'hFFFF, '0, 1);
            t++;
         end
         n_chk++;
         if (t >= 20 || bus.grant_idx != 4'(g % 16)) begin
            n_fail++;
            $display("FAIL fairness: grant %0d got idx=%0d valid=%b, expected idx=%0d", g, bus.grant_idx, bus.grant_valid, g % 16);
         end
         step(16'hFFFF, '0, 2);
         step(16'hFFFF, '1, 1);
         step(16'hFFFF, '0, 1);
      end
      step('0, '1, 3);
      do_reset('0);
      step(16'h0003, 16'h0000, 30);
      step('0, '1, 3);
      do_reset('0);
      step(16'h0001, 16'h0000, 3);
      step(16'h0100, 16'h0000, 5);
      step('0, '1, 3);
      do_reset('0);
      step(16'h0001, 16'h0000, 3);
      do_reset(16'h0010);
      step(16'h0010, 16'h0000, 3);
      step('0, '1, 3);
      r = '0;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 3) == 0) r = r ^ (N'(1) << $urandom_range(0, N - 1));
         f = ($urandom_range(0, 5) == 0) ? N'($urandom) : N'(0);
         step(r, f, 1);
         if ($urandom_range(0, 299) == 0) do_reset(r);
      end
      step('0, '1, 5);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d unmatched expected events, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/out_port_arbiter.md
# out_port_arbiter

Round-robin arbiter that shares one router output port among the 16 input channels of the 16x16 router. Each input FSM raises a request for this output once its 4-bit destination address is decoded. The arbiter grants exactly one input at a time and holds that grant until the frame ends. It drives the `busy` bit the input FSMs consult before loading data, so 16 instances generate the router's `busy[15:0]` vector.

## Interface
- `N_IN`, 16: number of requesting input channels.
- `MAX_HOLD`, 1024: maximum cycles one grant may last before forced release; must be ≥ 2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `req` in N_IN: level request per input; high while that input wants this output.
- `frame_n` in N_IN: per-input frame signal, active low; rising to 1 on the owner ends its frame.
- `grant` out N_IN: one-hot registered grant; all zero when no owner.
- `grant_idx` out $clog2(N_IN): index of current owner; valid only when `grant_valid`=1.
- `grant_valid` out 1: high while an owner holds the port.
- `busy` out 1: high whenever the port is not in IDLE; feeds `busy[port]` of the router.
- `abort` out 1: one-cycle pulse when a grant is withdrawn by the watchdog.

## Operation
- States: IDLE, GRANT, RELEASE (`arb_state_t`).
- IDLE:
  - If `req` is 0, remain in IDLE.
  - Otherwise pick the winner: the first set bit at or above `ptr` in round-robin order (ptr, ptr+1, … N_IN-1, 0, … ptr-1).
  - Go to GRANT, set `grant`/`grant_idx`/`grant_valid`, set `ptr` ← winner+1 mod N_IN, clear the hold counter.
- GRANT:
  - Owner release (owner `frame_n`=1 or owner `req`=0): go to RELEASE, clear `grant`/`grant_valid`.
  - Watchdog: if `hold_cnt` = MAX_HOLD-1 and no release, go to RELEASE, clear grant, assert `abort` for that one cycle.
  - Otherwise stay and increment `hold_cnt`.
  - Requests from non-owners are ignored.
- RELEASE: one turnaround cycle, `busy`=1, `grant`=0. Always go to IDLE.
- Release and watchdog in the same cycle: treat as a normal release; `abort` stays 0.
- Pointer arithmetic: `ptr` is $clog2(N_IN) bits, wraps N_IN-1 → 0. Winner N_IN-1 sets `ptr`=0.
- `hold_cnt` is $clog2(MAX_HOLD) bits, saturates conceptually (never exceeds MAX_HOLD-1).

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE; `grant`=0, `grant_idx`=0, `grant_valid`=0, `busy`=0, `abort`=0.
  - `ptr`=0, `hold_cnt`=0.
- Latency: `req` sampled high at edge k in IDLE → `grant`/`busy` high after edge k (visible cycle k+1).
- Release: owner `frame_n`=1 sampled at edge k → `grant`=0 after edge k; `busy`=0 after edge k+1. Earliest new grant is after edge k+2.
- Minimum gap between two grants is 2 cycles (RELEASE + IDLE evaluation).
- Maximum grant length is MAX_HOLD cycles.
- Reset mid-GRANT or mid-RELEASE: on the next edge with `reset`=1, all outputs return to reset values. No `abort` pulse is generated.
- A request arriving during RELEASE is evaluated in IDLE on the following edge.

## Structure
- Shared package `router_pkg`: `N_PORTS`=16, `ADDR_W`=4, `arb_state_t` enum (IDLE, GRANT, RELEASE).
- Sub-module `rr_pick`: purely combinational rotate-priority-rotate-back selector. Inputs `req` and `ptr`; outputs one-hot `win` and `win_idx`, plus `any`.
- The top holds the FSM, the pointer, the hold counter and the output registers.

## Test plan
- Single request: reset, then `req`=0x0004 → `grant`=0x0004, `grant_idx`=2, `busy`=1 one cycle later. Drive `frame_n[2]`=1 → `grant`=0 next cycle, `busy`=0 one cycle after that.
- Contention from `ptr`=0: `req`=0x8001 → input 0 wins, `ptr`=1. After release with `req` still 0x8001 → input 15 wins, `ptr` wraps to 0.
- Fairness: hold `req`=0xFFFF and release each grant after 3 cycles → grants in order 0,1,…,15,0. Each input is served exactly once per 16 grants.
- Watchdog: MAX_HOLD=8, owner keeps `frame_n`=0 and `req`=1 → `abort` pulses exactly once, 8 cycles after the grant rose. `grant` drops with it; the next grant goes to the next requester.
- Request drop: owner's `req` falls while `frame_n`=0 → normal release with no `abort`. In the same cycle a non-owner raises `req` → it is granted 2 cycles later.
- Reset mid-grant: assert `reset` for 1 cycle during GRANT → all outputs 0 and `ptr`=0 next cycle. With `req`=0x0010 → input 4 is granted one cycle after `reset` deasserts.
